// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU store-path widths, store buffer entry and flush state types
package cpu_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

  typedef enum logic {
    SB_IDLE  = 1'b0,
    SB_FLUSH = 1'b1
  } sb_state_t;

endpackage

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - store buffer CPU, load-forward and cache write port bundle
interface store_buffer_if
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) ();

  logic                    st_valid;
  logic                    st_ready;
  logic [ADDR_W-1:0]       st_addr;
  logic [DATA_W-1:0]       st_data;
  logic [ADDR_W-1:0]       ld_addr;
  logic                    ld_hit;
  logic [DATA_W-1:0]       ld_data;
  logic                    mem_busy;
  logic                    drain;
  logic                    we;
  logic [ADDR_W-1:0]       waddr;
  logic [DATA_W-1:0]       win;
  logic                    empty;
  logic [$clog2(DEPTH):0]  count;

  modport master (
    output st_valid, st_addr, st_data, ld_addr, mem_busy, drain,
    input  st_ready, ld_hit, ld_data, we, waddr, win, empty, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_addr, mem_busy, drain,
    output st_ready, ld_hit, ld_data, we, waddr, win, empty, count
  );

endinterface

// File: rtl/store_buffer_sb_match.sv
// rtl/store_buffer_sb_match.sv - combinational youngest-first load address match over pending stores
module sb_match
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  sb_entry_t                  entries [DEPTH],
  input  logic [DEPTH-1:0]           valid,
  input  logic [$clog2(DEPTH)-1:0]   tail,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic                       hit,
  output logic [DATA_W-1:0]          data
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk oldest (tail-DEPTH) to youngest (tail-1); a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = DEPTH; i >= 1; i--) begin
      idx = tail - PW'(i);
      if (valid[idx] && (entries[idx].addr == ld_addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store FIFO draining to the cache write port, with load forwarding and flush
module store_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  store_buffer_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t        mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] valid;
  sb_state_t        state;
  sb_state_t        state_nxt;
  logic             full;
  logic             enq;
  logic             deq;

  assign full         = (count == CW'(DEPTH));
  assign bus.empty    = (count == '0);
  assign bus.count    = count;
  assign bus.st_ready = !full && (state == SB_IDLE);
  assign enq          = bus.st_valid && bus.st_ready;
  assign deq          = !bus.empty && !bus.mem_busy;
  assign bus.we       = deq;
  assign bus.waddr    = bus.empty ? '0 : mem[head].addr;
  assign bus.win      = bus.empty ? '0 : mem[head].data;

  // A slot is live when its distance from head is below the pending count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_valid
    assign valid[g] = {1'b0, PW'(g) - head} < count;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        mem[tail] <= '{addr: bus.st_addr, data: bus.st_data};
        tail      <= tail + PW'(1);
      end
      if (deq) begin
        head <= head + PW'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SB_IDLE:  if (bus.drain) state_nxt = SB_FLUSH;
      SB_FLUSH: if (count == '0) state_nxt = SB_IDLE;
      default:  state_nxt = SB_IDLE;
    endcase
  end

  sb_match #(
    .DEPTH (DEPTH)
  ) u_match (
    .entries (mem),
    .valid   (valid),
    .tail    (tail),
    .ld_addr (bus.ld_addr),
    .hit     (bus.ld_hit),
    .data    (bus.ld_data)
  );

endmodule
